// File: rtl/flag_unit_pkg.sv
// Shared definitions for the branch-flag producer: opcodes, flag indices,
// unconditional condition code and FSM state type.
package flag_unit_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  localparam logic [2:0] COND_UNCOND = 3'b111;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } flag_state_t;

  // Per-flag write mask {V,N,Z} for an opcode.
  function automatic logic [2:0] flag_wr_mask(input logic [3:0] op);
    logic [2:0] mask;
    mask = 3'b000;
    unique case (op)
      OP_ADD, OP_SUB:                 mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = 3'b001;
      default:                        mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/flag_unit_if.sv
// EX/decode to flag-unit bundle. The pipeline side uses the master modport,
// the flag unit uses the slave modport.
interface flag_unit_if #(
  parameter int WIDTH = 16
);
  logic             ex_valid;
  logic             ex_flush;
  logic             pipe_stall;
  logic [3:0]       ex_opcode;
  logic [WIDTH-1:0] ex_result;
  logic             ex_ovfl;
  logic [1:0]       dec_branch;
  logic [2:0]       dec_cond;
  logic [2:0]       F;
  logic [2:0]       F_dec;
  logic             stall_req;
  logic             halted;

  modport master (
    output ex_valid, ex_flush, pipe_stall, ex_opcode, ex_result, ex_ovfl,
           dec_branch, dec_cond,
    input  F, F_dec, stall_req, halted
  );

  modport slave (
    input  ex_valid, ex_flush, pipe_stall, ex_opcode, ex_result, ex_ovfl,
           dec_branch, dec_cond,
    output F, F_dec, stall_req, halted
  );
endinterface

// File: rtl/flag_unit_compute.sv
// flag_compute: combinational {V,N,Z} values and per-flag write enables for
// one EX instruction; shared by the register write and the forward path.
module flag_compute
  import flag_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       i_opcode,
  input  logic [WIDTH-1:0] i_result,
  input  logic             i_ovfl,
  output logic [2:0]       o_flags,
  output logic [2:0]       o_we
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is inferred.
  always_comb begin
    o_flags         = 3'b000;
    o_flags[FLAG_Z] = ~|i_result;
    o_flags[FLAG_N] = i_result[WIDTH-1];
    o_flags[FLAG_V] = i_ovfl;
    o_we            = flag_wr_mask(i_opcode);
  end

endmodule

// File: rtl/flag_unit.sv
// flag_unit: architectural V/N/Z register, decode-stage flag supply and
// stale-flag stall request. Build option FLAG_FWD_EN forwards EX flags to
// decode instead of stalling.
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int         WIDTH       = 16,
  parameter logic [2:0] RESET_FLAGS = 3'b000
) (
  input logic          clk,
  input logic          rst_n,
  flag_unit_if.slave   bus
);

  flag_state_t r_state;
  logic [2:0]  r_flags;
  logic        r_halted;

  logic [2:0]  w_new;
  logic [2:0]  w_we;
  logic        w_live;
  logic        w_retire;
  logic        w_wr;
  logic        w_is_branch;
  logic        w_hz;
  logic [2:0]  w_f_dec;

  flag_compute #(.WIDTH(WIDTH)) u_compute (
    .i_opcode (bus.ex_opcode),
    .i_result (bus.ex_result),
    .i_ovfl   (bus.ex_ovfl),
    .o_flags  (w_new),
    .o_we     (w_we)
  );

  // A live EX instruction exists while running; it retires only when not held.
  assign w_live   = bus.ex_valid & ~bus.ex_flush & (r_state == RUN);
  assign w_retire = w_live & ~bus.pipe_stall;
  assign w_wr     = w_retire;

  always_comb begin
    w_is_branch = 1'b0;
    unique case (bus.dec_branch)
      2'b10, 2'b11: w_is_branch = 1'b1;
      default:      w_is_branch = 1'b0;
    endcase
  end

  // Hazard ignores pipe_stall: a held writer has still not updated F.
  assign w_hz = w_is_branch & (bus.dec_cond != COND_UNCOND) & w_live & (|w_we);

  // NOTE: state registers use non-blocking assignments and an asynchronous
  // active-low reset so every output returns to reset values immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_flags  <= RESET_FLAGS;
      r_halted <= 1'b0;
    end else begin
      unique case (r_state)
        RUN: begin
          for (int i = 0; i < 3; i++) begin
            if (w_wr && w_we[i]) r_flags[i] <= w_new[i];
          end
          if (w_retire && (bus.ex_opcode == OP_HLT)) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end
        end
        HALT: begin
          r_state  <= HALT;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef FLAG_FWD_EN
  always_comb begin
    w_f_dec = r_flags;
    for (int i = 0; i < 3; i++) begin
      if (w_hz && w_we[i]) w_f_dec[i] = w_new[i];
    end
  end
  assign bus.stall_req = 1'b0;
`else
  // Without forwarding, decode waits one cycle while the writer retires.
  assign w_f_dec       = r_flags;
  assign bus.stall_req = w_hz;
`endif

  assign bus.F      = r_flags;
  assign bus.F_dec  = w_f_dec;
  assign bus.halted = r_halted;

endmodule

// File: tb/tb_flag_unit.sv
// Table-driven bench for flag_unit with a scoreboard queue for registered
// results; expectations follow FLAG_FWD_EN when it is defined.
module tb_flag_unit;
  import flag_unit_pkg::*;

`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flag_unit_if #(.WIDTH(16)) bus ();

  flag_unit #(.WIDTH(16), .RESET_FLAGS(3'b000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic       valid, flush, stall;
    logic [3:0] op;
    logic [15:0] res;
    logic       ovfl;
    logic [1:0] br;
    logic [2:0] cond;
    logic [2:0] fdec_nf;   // F_dec this cycle, no forwarding
    logic [2:0] fdec_fw;   // F_dec this cycle, forwarding
    logic       stall_nf;  // stall_req this cycle, no forwarding
    logic [2:0] f_next;
    logic       halt_next;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] f;
    logic       halted;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic v, input logic fl, input logic st,
                              input logic [3:0] op, input logic [15:0] res, input logic ov,
                              input logic [1:0] br, input logic [2:0] cond,
                              input logic [2:0] fdnf, input logic [2:0] fdfw, input logic snf,
                              input logic [2:0] fn, input logic hn);
    vec_t t;
    t.name = name; t.valid = v; t.flush = fl; t.stall = st; t.op = op; t.res = res;
    t.ovfl = ov; t.br = br; t.cond = cond; t.fdec_nf = fdnf; t.fdec_fw = fdfw;
    t.stall_nf = snf; t.f_next = fn; t.halt_next = hn;
    return t;
  endfunction

  task automatic idle_inputs();
    bus.ex_valid = 1'b0; bus.ex_flush = 1'b0; bus.pipe_stall = 1'b0;
    bus.ex_opcode = OP_LW; bus.ex_result = 16'h0; bus.ex_ovfl = 1'b0;
    bus.dec_branch = 2'b00; bus.dec_cond = COND_UNCOND;
  endtask

  // Inputs are driven 1 time unit after a rising edge; combinational outputs
  // are sampled on the falling edge, registered ones 1 unit after the next rise.
  task automatic apply(input vec_t t);
    sb_t e;
    bus.ex_valid = t.valid; bus.ex_flush = t.flush; bus.pipe_stall = t.stall;
    bus.ex_opcode = t.op; bus.ex_result = t.res; bus.ex_ovfl = t.ovfl;
    bus.dec_branch = t.br; bus.dec_cond = t.cond;
    e.name = t.name; e.f = t.f_next; e.halted = t.halt_next;
    sb_q.push_back(e);
    @(negedge clk);
    check({t.name, " F_dec"}, 32'(bus.F_dec), 32'(FWD ? t.fdec_fw : t.fdec_nf));
    check({t.name, " stall_req"}, 32'(bus.stall_req), 32'(FWD ? 1'b0 : t.stall_nf));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({t.name, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.name, " F"}, 32'(bus.F), 32'(e.f));
      check({e.name, " halted"}, 32'(bus.halted), 32'(e.halted));
    end
  endtask

  initial begin
    //            name        v  fl st op      res      ov br     cond    Fdec_nf Fdec_fw stl F_next  halt
    vecs.push_back(mk("add_full",  1,0,0, OP_ADD, 16'h8000,1,2'b00,3'b111,3'b000,3'b000,0,3'b110,0));
    vecs.push_back(mk("sub_zero",  1,0,0, OP_SUB, 16'h0000,0,2'b00,3'b111,3'b110,3'b110,0,3'b001,0));
    vecs.push_back(mk("add_again", 1,0,0, OP_ADD, 16'h8000,1,2'b00,3'b111,3'b001,3'b001,0,3'b110,0));
    vecs.push_back(mk("xor_zonly", 1,0,0, OP_XOR, 16'h0000,0,2'b00,3'b111,3'b110,3'b110,0,3'b111,0));
    vecs.push_back(mk("lw_nowr",   1,0,0, OP_LW,  16'h0000,0,2'b00,3'b111,3'b111,3'b111,0,3'b111,0));
    vecs.push_back(mk("add_clear", 1,0,0, OP_ADD, 16'h0001,0,2'b00,3'b111,3'b111,3'b111,0,3'b000,0));
    vecs.push_back(mk("hz_sub",    1,0,0, OP_SUB, 16'h0000,0,2'b10,3'b001,3'b000,3'b001,1,3'b001,0));
    vecs.push_back(mk("hz_after",  0,0,0, OP_LW,  16'h0000,0,2'b10,3'b001,3'b001,3'b001,0,3'b001,0));
    vecs.push_back(mk("uncond",    1,0,0, OP_XOR, 16'h0001,0,2'b10,3'b111,3'b001,3'b001,0,3'b000,0));
    vecs.push_back(mk("flush_sub", 1,1,0, OP_SUB, 16'h0000,0,2'b10,3'b001,3'b000,3'b000,0,3'b000,0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk($sformatf("stall_add%0d", i),
                        1,0,1, OP_ADD, 16'h8000,1,2'b10,3'b010,3'b000,3'b110,1,3'b000,0));
    vecs.push_back(mk("stall_rel", 1,0,0, OP_ADD, 16'h8000,1,2'b10,3'b010,3'b000,3'b110,1,3'b110,0));
    vecs.push_back(mk("fl_st_hlt", 1,1,1, OP_HLT, 16'h0000,0,2'b00,3'b111,3'b110,3'b110,0,3'b110,0));
    vecs.push_back(mk("fl_hlt",    1,1,0, OP_HLT, 16'h0000,0,2'b00,3'b111,3'b110,3'b110,0,3'b110,0));
    vecs.push_back(mk("hz_br_xor", 1,0,0, OP_XOR, 16'h0000,0,2'b11,3'b000,3'b110,3'b111,1,3'b111,0));
    vecs.push_back(mk("hlt",       1,0,0, OP_HLT, 16'h0000,0,2'b00,3'b111,3'b111,3'b111,0,3'b111,1));
    vecs.push_back(mk("frozen",    1,0,0, OP_ADD, 16'hFFFF,0,2'b10,3'b001,3'b111,3'b111,0,3'b111,1));

    // Reset state, sampled while rst_n is low.
    idle_inputs();
    #3;
    check("rst F", 32'(bus.F), 32'h0);
    check("rst halted", 32'(bus.halted), 32'h0);
    check("rst stall_req", 32'(bus.stall_req), 32'h0);
    check("rst F_dec", 32'(bus.F_dec), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel F", 32'(bus.F), 32'h0);

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset from HALT, between clock edges.
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check("async F", 32'(bus.F), 32'h0);
    check("async halted", 32'(bus.halted), 32'h0);
    check("async stall_req", 32'(bus.stall_req), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply(mk("post_rst", 1,0,0, OP_ADD, 16'h0000,0,2'b00,3'b111,3'b000,3'b000,0,3'b001,0));

    check("sb drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Producer side of the branch-flag interface: owns the architectural V/N/Z flag register and drives the `F[2:0]` vector that the PC/branch-resolution logic consumes.
- Updates flags from EX-stage ALU results according to opcode.
- Supplies decode-stage branch logic with the correct flags, either forwarded or registered.
- Raises a stall request when a conditional branch would otherwise read stale flags.

Parameters:
- WIDTH, 16, ALU result width in bits.
- RESET_FLAGS, 3'b000, flag register value after reset ({V,N,Z}).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ex_valid  input  1  EX stage holds a real instruction.
- ex_flush  input  1  EX instruction is squashed this cycle; no flag write.
- pipe_stall  input  1  pipeline hold; EX instruction does not retire this cycle.
- ex_opcode  input  4  opcode of the EX instruction.
- ex_result  input  WIDTH  ALU result of the EX instruction.
- ex_ovfl  input  1  ALU signed overflow for ADD/SUB.
- dec_branch  input  2  decode branch type; [1]=branch instruction, [0]=BR (register) vs B.
- dec_cond  input  3  decode condition code; 3'b111 = unconditional.
- F  output  3  registered flags: [2]=V, [1]=N, [0]=Z.
- F_dec  output  3  flags the decode-stage branch logic uses this cycle.
- stall_req  output  1  request to hold fetch/decode one cycle.
- halted  output  1  HLT has retired; flags are frozen.

Behaviour:
- Reset (async, rst_n=0): F=RESET_FLAGS, state=RUN, halted=0. F_dec and stall_req are derived combinationally from that state.
- Write qualifier: wr = ex_valid & ~ex_flush & ~pipe_stall & (state==RUN).
- Per-flag write enables:
  - ADD 4'h0, SUB 4'h1: write Z, N, V.
  - XOR 4'h2, SLL 4'h4, SRA 4'h5, ROR 4'h6: write Z only.
  - All other opcodes (RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT): write nothing.
- Flag values:
  - Z = (ex_result == 0).
  - N = ex_result[WIDTH-1].
  - V = ex_ovfl.
  - When N/V are not enabled they keep their previous values.
- Latency: F reflects a writing instruction on the rising edge after the cycle in which wr=1.
- Flag-hazard condition: hz = dec_branch[1] & (dec_cond != 3'b111) & ex_valid & ~ex_flush & (ex_opcode is a flag writer) & (state==RUN).
- State machine: RUN -> HALT when ex_valid & ~ex_flush & ~pipe_stall & ex_opcode==4'hF. HALT is terminal until reset. In HALT: halted=1, F is frozen, stall_req=0.
- pipe_stall=1: F holds. hz is still evaluated, since the EX instruction has not yet written.
- ex_flush and pipe_stall both asserted: no write, no state change.
- Reset asserted mid-stall or mid-hazard: outputs return to reset values immediately (asynchronously).

Optional Feature:
- Macro: FLAG_FWD_EN.
- Defined:
  - F_dec is computed combinationally: for each enabled flag, take the newly computed EX value when hz=1 and that flag is enabled; otherwise take F.
  - stall_req is tied 0.
- Undefined:
  - F_dec = F.
  - stall_req = hz, so it asserts for exactly one cycle per hazard because the EX writer retires on the next edge.
  - If pipe_stall holds EX, stall_req stays high until the writer retires.

Decomposition:
- Shared package holds:
  - opcode localparams (OP_ADD .. OP_HLT);
  - flag index constants (FLAG_V=2, FLAG_N=1, FLAG_Z=0);
  - COND_UNCOND=3'b111;
  - typedef enum {RUN, HALT} flag_state_t.
- One sub-module, flag_compute: combinational. Takes opcode, result, and ovfl; returns 3-bit flag values and 3-bit per-flag write enables. It is used for both the register write and the forward path.

Test Plan:
- Reset: rst_n=0 with FLAG_FWD_EN undefined -> F=3'b000, halted=0, stall_req=0. Release reset -> F unchanged.
- Full flag write: ADD, ex_result=16'h8000, ex_ovfl=1, wr=1 -> F=3'b110 next edge. Then SUB, ex_result=16'h0000, ex_ovfl=0 -> F=3'b001.
- Z-only write: from F=3'b110, XOR with ex_result=16'h0000 -> F=3'b111 (V and N retained). Then LW with ex_result=16'h0000 -> F unchanged.
- Hazard:
  - Setup: SUB in EX (ex_result=0), dec_branch=2'b10, dec_cond=3'b001.
  - FLAG_FWD_EN undefined: stall_req=1 for one cycle, F_dec=old F; next cycle stall_req=0 and F_dec[0]=1.
  - FLAG_FWD_EN defined: stall_req=0 and F_dec[0]=1 in the same cycle.
  - dec_cond=3'b111 with the same EX instruction -> stall_req=0.
- Flush and stall: SUB with ex_flush=1 -> no F change and stall_req=0. ADD with pipe_stall=1 for 3 cycles -> F holds; stall_req high for all 3 cycles if FLAG_FWD_EN is undefined; write lands on the first edge with pipe_stall=0.
- Halt: HLT retires -> halted=1 next edge. A subsequent ADD with ex_result=16'hFFFF -> F frozen. Then rst_n pulse -> halted=0, F=RESET_FLAGS.
